codec_resp: RTL and testbench

- Synthesizable serial-audio CODEC responder: the slave end of the LRCLK/SCLK/SDin/SDout link that our codec master drives.
- Captures DAC words arriving on SDin into parallel left/right registers.
- Serializes ADC words from a small push FIFO onto SDout.
- Used as a loopback/BFM endpoint in the core-level bench, and on FPGA when no physical CODEC is fitted.
- Runs on the system clock; oversamples the master's clocks.

---
 rtl/codec_resp.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_codec_resp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/codec_resp.sv
`default_nettype none
// ============================================================================
//  Module   : codec_resp
//  Purpose  : Serial-audio CODEC responder. Oversamples the master's
//             LRCLK/SCLK/SDin/RSTn, captures DAC words into parallel
//             left/right registers and serializes ADC sample pairs from a
//             small push FIFO onto SDout.
//  Revision : 1.0  initial release
// ============================================================================
module codec_resp #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LRCLK,
    input  logic             SCLK,
    input  logic             RSTn,
    input  logic             SDin,
    output logic             SDout,
    input  logic [WIDTH-1:0] adc_lft,
    input  logic [WIDTH-1:0] adc_rht,
    input  logic             adc_push,
    output logic             adc_full,
    output logic [WIDTH-1:0] dac_lft,
    output logic [WIDTH-1:0] dac_rht,
    output logic             dac_vld,
    output logic             frame_err,
    output logic             underrun,
    input  logic             err_clr
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [4:0]         c_BITS_OK  = 5'(WIDTH);
    localparam logic [4:0]         c_BITS_SAT = 5'd31;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ALIGN = 2'd1;
    localparam logic [1:0] c_ST_LEFT  = 2'd2;
    localparam logic [1:0] c_ST_RIGHT = 2'd3;

    // ------------------------------------------------------------------
    // Synchronizers: bit0 LRCLK, bit1 SCLK, bit2 SDin, bit3 RSTn.
    // Only the clocks need a third stage for edge detection.
    // ------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [1:0] r_sync3;

    // Two-flop synchronizer plus edge-detect delay stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= {RSTn, SDin, SCLK, LRCLK};
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2[1:0];
        end
    end

    logic w_lr_s;
    logic w_sdin_s;
    logic w_rstn_s;
    logic w_lr_rise;
    logic w_lr_fall;
    logic w_lr_edge;
    logic w_sclk_rise;
    logic w_sclk_fall;

    assign w_lr_s      = r_sync2[0];
    assign w_sdin_s    = r_sync2[2];
    assign w_rstn_s    = r_sync2[3];
    assign w_lr_rise   =  w_lr_s     & ~r_sync3[0];
    assign w_lr_fall   = ~w_lr_s     &  r_sync3[0];
    assign w_lr_edge   = w_lr_rise | w_lr_fall;
    assign w_sclk_rise =  r_sync2[1] & ~r_sync3[1];
    assign w_sclk_fall = ~r_sync2[1] &  r_sync3[1];

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [4:0]         r_bit_cnt;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_rht_hold;
    logic               r_sdout;
    logic               r_lft_got;
    logic [WIDTH-1:0]   r_dac_lft;
    logic [WIDTH-1:0]   r_dac_rht;
    logic               r_dac_vld;
    logic               r_frame_err;
    logic               r_underrun;

    logic [2*WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // Next-state logic for the serial datapaths
    // ------------------------------------------------------------------
    logic               w_active;
    logic               w_in_half;
    logic               w_load_rise;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;
    logic [2*WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0]   w_rx_next;
    logic [4:0]         w_cnt_next;
    logic [WIDTH-1:0]   w_tx_next;
    logic [WIDTH-1:0]   w_hold_next;
    logic [1:0]         w_state_next;
    logic               w_ferr_set;
    logic               w_uflow_set;
    logic               w_cap_l;
    logic               w_cap_r;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_rd_data = r_mem[r_rd_ptr];

    // Receive/transmit shifters, frame tracking and error detection
    always_comb begin
        w_active    = w_rstn_s && (r_state != c_ST_IDLE);
        w_in_half   = (r_state == c_ST_LEFT) || (r_state == c_ST_RIGHT);
        // A new frame starts on LRCLK rise when leaving ALIGN or RIGHT
        w_load_rise = w_active && w_lr_rise &&
                      ((r_state == c_ST_ALIGN) || (r_state == c_ST_RIGHT));
        w_pop       = w_load_rise && !w_empty;
        w_uflow_set = w_load_rise && w_empty;

        // Bit shifted in on an SCLK rise is included in a coincident capture
        w_rx_next  = r_rx_shift;
        w_cnt_next = r_bit_cnt;
        if (w_sclk_rise) begin
            w_rx_next = {r_rx_shift[WIDTH-2:0], w_sdin_s};
            if (r_bit_cnt != c_BITS_SAT) begin
                w_cnt_next = r_bit_cnt + 5'd1;
            end
        end

        w_ferr_set = w_active && w_in_half && w_lr_edge && (w_cnt_next != c_BITS_OK);
        w_cap_l    = w_active && (r_state == c_ST_LEFT)  && w_lr_fall;
        w_cap_r    = w_active && (r_state == c_ST_RIGHT) && w_lr_rise;

        // LRCLK edges take priority over the SCLK fall the master pairs with them
        w_tx_next   = r_tx_shift;
        w_hold_next = r_rht_hold;
        if (w_load_rise) begin
            if (w_empty) begin
                w_tx_next   = '0;
                w_hold_next = '0;
            end else begin
                w_tx_next   = w_rd_data[2*WIDTH-1:WIDTH];
                w_hold_next = w_rd_data[WIDTH-1:0];
            end
        end else if (w_lr_fall && (r_state == c_ST_LEFT)) begin
            w_tx_next = r_rht_hold;
        end else if (w_sclk_fall && !w_lr_edge) begin
            w_tx_next = {r_tx_shift[WIDTH-2:0], r_tx_shift[WIDTH-1]};
        end

        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  w_state_next = c_ST_ALIGN;
            c_ST_ALIGN: if (w_lr_rise) w_state_next = c_ST_LEFT;
            c_ST_LEFT:  if (w_lr_fall) w_state_next = c_ST_RIGHT;
            c_ST_RIGHT: if (w_lr_rise) w_state_next = c_ST_LEFT;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Frame state machine, shift registers and DAC word capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rht_hold <= '0;
            r_sdout    <= 1'b0;
            r_lft_got  <= 1'b0;
            r_dac_lft  <= '0;
            r_dac_rht  <= '0;
            r_dac_vld  <= 1'b0;
        end else begin
            r_dac_vld <= 1'b0;
            if (!w_rstn_s || (r_state == c_ST_IDLE)) begin
                // CODEC held in reset: silence the link and forget the frame
                r_state    <= w_rstn_s ? c_ST_ALIGN : c_ST_IDLE;
                r_rx_shift <= '0;
                r_bit_cnt  <= '0;
                r_tx_shift <= '0;
                r_rht_hold <= '0;
                r_sdout    <= 1'b0;
                r_lft_got  <= 1'b0;
            end else begin
                r_state    <= w_state_next;
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= w_lr_edge ? 5'd0 : w_cnt_next;
                r_tx_shift <= w_tx_next;
                r_rht_hold <= w_hold_next;
                r_sdout    <= w_tx_next[WIDTH-1];
                if (w_cap_l) begin
                    r_dac_lft <= w_rx_next;
                    r_lft_got <= 1'b1;
                end
                if (w_cap_r) begin
                    r_dac_rht <= w_rx_next;
                    r_dac_vld <= r_lft_got;
                end
            end
        end
    end

    // Sticky error flags; a new set condition beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_uflow_set) begin
                r_underrun <= 1'b1;
            end else if (err_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // ADC sample-pair FIFO. A pop in the same cycle frees a slot, so a
    // push while full is still accepted then.
    // ------------------------------------------------------------------
    assign w_push_ok = adc_push && w_rstn_s && (!w_full || w_pop);

    // FIFO pointers and occupancy; flushed while the CODEC is in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (!w_rstn_s) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage, left word in the upper half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {adc_lft, adc_rht};
        end
    end

    assign SDout     = r_sdout;
    assign adc_full  = w_full;
    assign dac_lft   = r_dac_lft;
    assign dac_rht   = r_dac_rht;
    assign dac_vld   = r_dac_vld;
    assign frame_err = r_frame_err;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_codec_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_codec_resp
//  Purpose  : Directed self-checking bench for codec_resp. A behavioural
//             master drives LRCLK/SCLK/SDin (SCLK period 32 clk) and
//             shifts SDout in on every SCLK rise.
//  Revision : 1.0  initial release
// ============================================================================
module tb_codec_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        LRCLK;
    logic        SCLK;
    logic        RSTn;
    logic        SDin;
    logic        SDout;
    logic [15:0] adc_lft;
    logic [15:0] adc_rht;
    logic        adc_push;
    logic        adc_full;
    logic [15:0] dac_lft;
    logic [15:0] dac_rht;
    logic        dac_vld;
    logic        frame_err;
    logic        underrun;
    logic        err_clr;

    int          checks   = 0;
    int          failures = 0;
    int          vld_cnt  = 0;
    int          sd_ones  = 0;
    int          v0;
    int          s0;
    logic [15:0] got;

    logic [15:0] tl [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic [15:0] tr [5] = '{16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

    codec_resp #(.FIFO_DEPTH(4), .WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .LRCLK     (LRCLK),
        .SCLK      (SCLK),
        .RSTn      (RSTn),
        .SDin      (SDin),
        .SDout     (SDout),
        .adc_lft   (adc_lft),
        .adc_rht   (adc_rht),
        .adc_push  (adc_push),
        .adc_full  (adc_full),
        .dac_lft   (dac_lft),
        .dac_rht   (dac_rht),
        .dac_vld   (dac_vld),
        .frame_err (frame_err),
        .underrun  (underrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Count dac_vld pulses and cycles with SDout high
    always @(negedge clk) begin
        if (dac_vld) vld_cnt <= vld_cnt + 1;
        if (SDout)   sd_ones <= sd_ones + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One half-frame: LRCLK and SCLK fall together, then nbits SCLK periods
    task automatic half(input logic lvl, input logic [15:0] word, input int nbits);
        LRCLK = lvl;
        SCLK  = 1'b0;
        got   = '0;
        for (int i = 0; i < nbits; i++) begin
            SDin = word[15-i];
            tick(16);
            SCLK = 1'b1;
            got  = {got[14:0], SDout};
            tick(16);
            if (i != nbits - 1) SCLK = 1'b0;
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        adc_lft  = l;
        adc_rht  = r;
        adc_push = 1'b1;
        tick(1);
        adc_push = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; RSTn = 1'b0; LRCLK = 1'b0; SCLK = 1'b0; SDin = 1'b0;
        adc_lft = '0; adc_rht = '0; adc_push = 1'b0; err_clr = 1'b0;
        tick(5);
        chk("rst_sdout",    32'(SDout),     32'h0);
        chk("rst_dac_lft",  32'(dac_lft),   32'h0);
        chk("rst_dac_rht",  32'(dac_rht),   32'h0);
        chk("rst_dac_vld",  32'(dac_vld),   32'h0);
        chk("rst_frame_err",32'(frame_err), 32'h0);
        chk("rst_underrun", 32'(underrun),  32'h0);
        chk("rst_adc_full", 32'(adc_full),  32'h0);
        rst_n = 1'b1;
        tick(3);
        RSTn = 1'b1;
        tick(10);

        // Loopback and ADC transmit of one pushed pair
        push(16'h8001, 16'h7FFE);
        chk("full_one", 32'(adc_full), 32'h0);
        half(1'b1, 16'hA5C3, 16);
        chk("tx_left", 32'(got), 32'h8001);
        half(1'b0, 16'h1234, 16);
        chk("tx_right",  32'(got),       32'h7FFE);
        chk("dac_lft",   32'(dac_lft),   32'hA5C3);
        chk("no_uflow",  32'(underrun),  32'h0);
        chk("no_ferr",   32'(frame_err), 32'h0);
        chk("no_vld_yet",32'(vld_cnt),   32'h0);
        half(1'b1, 16'hA5C3, 16);
        s0 = sd_ones;
        chk("dac_rht",   32'(dac_rht),  32'h1234);
        chk("vld_first", 32'(vld_cnt),  32'h1);
        chk("empty_l",   32'(got),      32'h0);
        chk("uflow_set", 32'(underrun), 32'h1);
        half(1'b0, 16'h1234, 16);
        chk("empty_r", 32'(got), 32'h0);

        // Further empty frames, then clear and re-set underrun
        for (int f = 0; f < 2; f++) begin
            half(1'b1, 16'hA5C3, 16);
            half(1'b0, 16'h1234, 16);
        end
        chk("sdout_zero", 32'(sd_ones - s0), 32'h0);
        chk("uflow_held", 32'(underrun),     32'h1);
        chk("vld_frames", 32'(vld_cnt),      32'h3);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(2);
        chk("uflow_clr", 32'(underrun),  32'h0);
        chk("ferr_clean",32'(frame_err), 32'h0);
        half(1'b1, 16'hC0DE, 16);
        chk("uflow_reset", 32'(underrun), 32'h1);
        half(1'b0, 16'h1234, 16);

        // Five back-to-back pushes into a depth-4 FIFO
        for (int k = 0; k < 5; k++) begin
            adc_lft  = tl[k];
            adc_rht  = tr[k];
            adc_push = 1'b1;
            tick(1);
            if (k == 3) chk("full_after4", 32'(adc_full), 32'h1);
        end
        adc_push = 1'b0;
        for (int k = 0; k < 4; k++) begin
            half(1'b1, 16'hA5C3, 16);
            chk("fifo_l", 32'(got), 32'(tl[k]));
            if (k == 0) chk("full_drop", 32'(adc_full), 32'h0);
            half(1'b0, 16'h1234, 16);
            chk("fifo_r", 32'(got), 32'(tr[k]));
        end
        half(1'b1, 16'hA5C3, 16);
        chk("fifth_dropped", 32'(got), 32'h0);
        half(1'b0, 16'h1234, 16);

        // Short left half: 15 SCLK rises
        chk("ferr_before", 32'(frame_err), 32'h0);
        half(1'b1, 16'hBEEF, 15);
        half(1'b0, 16'h1234, 16);
        chk("ferr_short", 32'(frame_err), 32'h1);
        chk("short_word", 32'(dac_lft),   32'h5F77);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(2);
        chk("ferr_clr", 32'(frame_err), 32'h0);
        half(1'b1, 16'hA5C3, 16);
        chk("ferr_good", 32'(frame_err), 32'h0);
        chk("rht_after", 32'(dac_rht),   32'h1234);

        // CODEC reset mid-left-half
        half(1'b0, 16'h1234, 16);
        push(16'hFFFF, 16'h0000);
        half(1'b1, 16'hA5C3, 8);
        chk("sdout_pre", 32'(SDout), 32'h1);
        chk("got_pre",   32'(got),   32'h00FF);
        v0 = vld_cnt;
        RSTn = 1'b0;
        tick(5);
        chk("sdout_rst", 32'(SDout), 32'h0);
        tick(20);
        RSTn = 1'b1;
        tick(10);
        half(1'b1, 16'h0000, 8);
        half(1'b0, 16'h1234, 16);
        chk("vld_align", 32'(vld_cnt - v0), 32'h0);
        half(1'b1, 16'h3C5A, 16);
        half(1'b0, 16'h0F0F, 16);
        half(1'b1, 16'hA5C3, 16);
        chk("vld_resume", 32'(vld_cnt - v0), 32'h1);
        chk("lft_resume", 32'(dac_lft),      32'h3C5A);
        chk("rht_resume", 32'(dac_rht),      32'h0F0F);
        chk("ferr_resume",32'(frame_err),    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
